// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with private HI/LO and MFHI/MFLO/MTHI/MTLO support.
// Latency DATA_W+1 cycles (divide by zero: 1); stall held while busy. Option: MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mf_data
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // acc: product (MUL) or partial remainder (DIV); mcand: shifted multiplicand or divisor;
    // mplier: multiplier (MUL) or dividend shifting out / quotient shifting in (DIV)
    logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                neg_q, neg_d, rem_neg_q, rem_neg_d;

    logic                is_md, is_mf, is_mt, is_signed, last;
    logic [DATA_W-1:0]   abs_rs, abs_rt, quot, new_rem;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   diff;

    assign is_md     = (funct[5:2] == 4'b0110);
    assign is_mf     = (funct[5:2] == 4'b0100) && !funct[0];
    assign is_mt     = (funct[5:2] == 4'b0100) &&  funct[0];
    assign is_signed = !funct[0];
    assign abs_rs    = (is_signed && rs_data[DATA_W-1]) ? -rs_data : rs_data;
    assign abs_rt    = (is_signed && rt_data[DATA_W-1]) ? -rt_data : rt_data;

    assign prod      = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_fix  = neg_q ? -prod : prod;
    assign shifted   = {acc_q[DATA_W-1:0], mplier_q[DATA_W-1]};
    assign diff      = {1'b0, shifted} - {2'b00, mcand_q[DATA_W-1:0]};
    assign new_rem   = diff[DATA_W+1] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quot      = {mplier_q[DATA_W-2:0], !diff[DATA_W+1]};

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        stall     = 1'b0;
        last      = (cnt_q == CNT_W'(DATA_W-1));
        case (state_q)
            S_IDLE: begin
                stall = op_valid && is_md;
                if (op_valid && is_md && !flush) begin
                    neg_d     = is_signed && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                    rem_neg_d = is_signed && rs_data[DATA_W-1];
                    cnt_d     = '0;
                    acc_d     = '0;
                    if (funct[1]) begin
                        if (rt_data == '0) begin
                            hi_d    = rs_data;
                            lo_d    = '1;
                            state_d = S_DONE;
                        end else begin
                            mplier_d = abs_rs;
                            mcand_d  = {{DATA_W{1'b0}}, abs_rt};
                            state_d  = S_DIV;
                        end
                    end else begin
                        mcand_d  = {{DATA_W{1'b0}}, abs_rs};
                        mplier_d = abs_rt;
                        state_d  = S_MUL;
                    end
                end else if (op_valid && is_mt && !flush) begin
                    if (funct[1]) lo_d = rs_data;
                    else          hi_d = rs_data;
                end
            end
            S_MUL: begin
                stall    = 1'b1;
                acc_d    = prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                last     = last || ((mplier_q >> 1) == '0);
`endif
                if (last) begin
                    hi_d    = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d    = prod_fix[DATA_W-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                stall    = 1'b1;
                acc_d    = {{DATA_W{1'b0}}, new_rem};
                mplier_d = quot;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    lo_d    = neg_q     ? -quot    : quot;
                    hi_d    = rem_neg_q ? -new_rem : new_rem;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign done    = (state_q == S_DONE);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = (op_valid && is_mf) ? (funct[1] ? lo_q : hi_q) : '0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic results, stall/done timing, MF/MT, flush and reset.
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU  = 6'b011011,
                           F_MFHI = 6'b010000, F_MFLO  = 6'b010010,
                           F_MTHI = 6'b010001, F_MTLO  = 6'b010011;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SMALL_STALLS = 3;
`else
    localparam int SMALL_STALLS = 33;
`endif

    logic        clk = 1'b0, reset = 1'b0, op_valid = 1'b0, flush = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        stall, done;
    logic [31:0] hi, lo, mf_data;
    int checks = 0, failures = 0;

    ex_muldiv_unit #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .stall(stall), .done(done), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; funct = f; rs_data = a; rt_data = b;
    endtask

    // Holds the instruction until done; counts stalled cycles seen before it.
    task automatic wait_done(output int stalls, output bit seen);
        stalls = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done) begin seen = 1'b1; break; end
            if (stall) stalls++;
            @(negedge clk);
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mf_data !== 32'h0) begin failures++; $display("FAIL reset_mf got=%h exp=0", mf_data); end
        reset = 1'b1;
    endtask

    task automatic test_mul;
        int st; bit seen;
        start_op(F_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done(st, seen);
        checks++; if (!seen) begin failures++; $display("FAIL mult_done got=0 exp=1"); end
        checks++; if (st != 33) begin failures++; $display("FAIL mult_stalls got=%0d exp=33", st); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_stall_in_done got=%b exp=0", stall); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end

        start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(st, seen);
        checks++; if (!seen || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            failures++; $display("FAIL multu_max got=%b/%h/%h exp=1/fffffffe/00000001", seen, hi, lo); end

        start_op(F_MULTU, 32'd5, 32'd3);
        wait_done(st, seen);
        checks++; if (st != SMALL_STALLS) begin failures++; $display("FAIL multu_small_stalls got=%0d exp=%0d", st, SMALL_STALLS); end
        checks++; if (!seen || hi !== 32'h0 || lo !== 32'd15) begin
            failures++; $display("FAIL multu_small got=%b/%h/%h exp=1/0/f", seen, hi, lo); end
    endtask

    task automatic test_div;
        int st; bit seen;
        start_op(F_DIVU, 32'd100, 32'd7);
        wait_done(st, seen);
        checks++; if (st != 33) begin failures++; $display("FAIL divu_stalls got=%0d exp=33", st); end
        checks++; if (!seen || lo !== 32'd14 || hi !== 32'd2) begin
            failures++; $display("FAIL divu got=%b/%h/%h exp=1/e/2", seen, lo, hi); end

        start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(st, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL div_neg got=%b/%h/%h exp=1/fffffffd/ffffffff", seen, lo, hi); end

        start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(st, seen);
        checks++; if (!seen || lo !== 32'h8000_0000 || hi !== 32'h0) begin
            failures++; $display("FAIL div_ovf got=%b/%h/%h exp=1/80000000/0", seen, lo, hi); end

        start_op(F_DIV, 32'h1234, 32'h0);
        wait_done(st, seen);
        checks++; if (st != 1) begin failures++; $display("FAIL div0_stalls got=%0d exp=1", st); end
        checks++; if (!seen || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL div0 got=%b/%h/%h exp=1/1234/ffffffff", seen, hi, lo); end
    endtask

    task automatic test_flush;
        int pulses = 0;
        start_op(F_MULT, 32'd7, 32'hFFFF_FFFD);
        repeat (16) @(negedge clk);
        flush = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_idle stall got=%b exp=0", stall); end
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk); #1;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL flush_done got=%0d exp=0", pulses); end
        checks++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL flush_hilo got=%h/%h exp=1234/ffffffff", hi, lo); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        start_op(F_MULT, 32'd7, 32'hFFFF_FFFD);
        repeat (16) @(negedge clk);
        reset = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++; $display("FAIL rst_mid got=%b/%h/%h exp=0/0/0", stall, hi, lo); end
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk); #1;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_mf_mt;
        int bad = 0; bit seen = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; funct = F_MTLO; rs_data = 32'd5; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL mt_flush got=%h exp=0", lo); end

        @(negedge clk);
        op_valid = 1'b1; funct = F_MTHI; rs_data = 32'hABCD;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall); end
        @(negedge clk);
        funct = F_MFHI;
        #1;
        checks++; if (hi !== 32'hABCD) begin failures++; $display("FAIL mthi got=%h exp=abcd", hi); end
        checks++; if (mf_data !== 32'hABCD) begin failures++; $display("FAIL mfhi got=%h exp=abcd", mf_data); end

        start_op(F_DIVU, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        funct = F_MFLO;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done) begin seen = 1'b1; break; end
            if (!stall) bad++;
            @(negedge clk);
        end
        checks++; if (!seen || bad != 0) begin failures++; $display("FAIL mf_busy_stall got=%b/%0d exp=1/0", seen, bad); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mf_done_stall got=%b exp=0", stall); end
        checks++; if (mf_data !== 32'd14) begin failures++; $display("FAIL mflo_after got=%h exp=e", mf_data); end
        op_valid = 1'b0;
        #1;
        checks++; if (mf_data !== 32'h0) begin failures++; $display("FAIL mf_idle got=%h exp=0", mf_data); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_mf_mt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the ID/EX pipeline register outputs: rs/rt operand data and the funct field.
- Executes MIPS MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers, and services MFHI/MFLO/MTHI/MTLO.
- Asserts stall back to the hazard logic, which holds IF/ID and ID/EX while an operation is in flight.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
op_valid  input  1  ID/EX holds a valid R-type instruction this cycle
funct  input  6  ID/EX funct field
rs_data  input  DATA_W  ID/EX read data 1 (dividend / multiplicand / MT source)
rt_data  input  DATA_W  ID/EX read data 2 (divisor / multiplier)
flush  input  1  abort in-flight operation (branch/exception squash)
stall  output  1  hold IF/ID and ID/EX; combinational
done  output  1  one-cycle pulse, HI/LO just updated by MULT/DIV
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register
mf_data  output  DATA_W  MFHI→hi, MFLO→lo, else 0; combinational

Behaviour:
- Decode: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 (is_md); MFHI 010000, MFLO 010010 (is_mf); MTHI 010001, MTLO 010011 (is_mt).
- Reset: state=IDLE, hi=lo=0, done=0, counter=0, internal accumulators 0. stall follows its combinational equation (0 when op_valid=0).
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - At an edge with op_valid&is_md&!flush: latch |rs|, |rt| (signed ops) or raw values, plus result-sign flags; counter=0; go to MUL or DIV.
  - op_valid&is_mt&!flush: write hi or lo with rs_data at that edge; stay IDLE.
- MUL: shift-add, one multiplier bit per cycle, 2*DATA_W product accumulator.
- DIV: restoring division, one quotient bit per cycle.
- After DATA_W iterations:
  - Sign-correct the result: MULT negates product if signs differ; DIV negates quotient if signs differ, remainder takes dividend sign.
  - Load hi/lo at that edge and go to DONE.
  - Mul: hi=product[2W-1:W], lo=product[W-1:0]. Div: lo=quotient, hi=remainder.
- Divide by zero (rt_data==0 at accept): skip iteration. Go directly IDLE→DONE with hi=rs_data, lo=all ones at the accept edge.
- DONE: done=1, stall=0, op_valid ignored (the same instruction advances out of ID/EX at this edge); next state IDLE.
- Latency: accept edge E0; HI/LO valid after edge E(DATA_W); done high in the cycle after E(DATA_W).
- stall = (state==MUL|DIV) | (state==IDLE & op_valid & is_md & !rt_zero_path) | (state==IDLE & op_valid & is_md & rt==0). Net effect: any is_md in IDLE stalls for its accept cycle.
  - Additionally, stall=1 when op_valid&(is_mf|is_mt) and state is MUL or DIV. MF/MT never observe partial results and are not applied while busy.
  - stall always 0 in DONE.
- flush: in any state, flush=1 at an edge forces state=IDLE and suppresses done. hi/lo keep their prior values. An MT with flush=1 is not applied.
- Reset mid-operation: IDLE, hi=lo=0 at that edge. No done pulse.
- Arithmetic modulo 2^DATA_W per field. Signed edge case: DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - MUL terminates once the remaining unshifted multiplier bits are all zero, minimum 1 iteration. It then applies sign correction, loads hi/lo and enters DONE.
  - Multiplier 0 completes in 1 iteration.
  - DIV is unchanged.
- Undefined: MUL always takes exactly DATA_W iterations.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) → after 32 iterations hi=0xFFFFFFFF, lo=0xFFFFFFEB. stall high for exactly 33 cycles, then done for 1 cycle.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULTU rs=5, rt=3 completes after 2 iterations with MULDIV_EARLY_OUT_EN, 32 without.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV rs=0x1234, rt=0 → next cycle done=1, hi=0x1234, lo=0xFFFFFFFF, stall high only on accept cycle.
- MFLO presented during DIV iteration 10 → stall=1 until DONE. mf_data then equals new lo. MTHI 0xABCD in IDLE → hi=0xABCD next cycle, no stall.
- Reset=0 at iteration 15 of MULT → next cycle state IDLE, hi=lo=0, no done. flush at iteration 15 → IDLE, hi/lo retain previous values, no done.
